// File: rtl/uartb_pkg.sv
// Shared types and constants for the UARTB transmit scheduler.
package uartb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_SETTLE,
    ST_SEND,
    ST_WAIT
  } state_t;

  localparam int MODE_BIT      = 31;
  localparam int BITS_PER_CHAR = 10;
  localparam int BURST_BYTES   = 4;

  // Bit times per transmit write: one character, or a full 4-byte burst.
  function automatic logic [5:0] char_factor(input logic burst);
    return burst ? 6'(BITS_PER_CHAR * BURST_BYTES) : 6'(BITS_PER_CHAR);
  endfunction

endpackage

// File: rtl/uartb_tx_sched_if.sv
// Requester handshake and UARTB_CORE drive bundle for the transmit scheduler.
interface uartb_tx_sched_if;
  logic [15:0] cfg_div;
  logic        req0_valid;
  logic [31:0] req0_data;
  logic        req0_burst;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_data;
  logic        req1_burst;
  logic        req1_ready;
  logic [31:0] uart_d;
  logic        uart_wrtx;
  logic        uart_wrbaud;
  logic        busy;
  logic        cur_mode;
  logic        grant_id;

  modport master (
    output cfg_div,
    output req0_valid, req0_data, req0_burst,
    output req1_valid, req1_data, req1_burst,
    input  req0_ready, req1_ready,
    input  uart_d, uart_wrtx, uart_wrbaud,
    input  busy, cur_mode, grant_id
  );

  modport slave (
    input  cfg_div,
    input  req0_valid, req0_data, req0_burst,
    input  req1_valid, req1_data, req1_burst,
    output req0_ready, req1_ready,
    output uart_d, uart_wrtx, uart_wrbaud,
    output busy, cur_mode, grant_id
  );
endinterface

// File: rtl/uartb_char_timer.sv
// Character-time down-counter: loads (div+1)*10*nbytes + GUARD_CYC, flags the last cycle.
module uartb_char_timer
  import uartb_pkg::*;
#(
  parameter int GUARD_CYC = 2,
  parameter int CNT_W     = 22
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] div,
  input  logic        burst,
  output logic        done
);

  logic [16:0]      bit_cyc;
  logic [CNT_W-1:0] n_load;
  logic [CNT_W-1:0] cnt;

  assign bit_cyc = {1'b0, div} + 17'd1;
  assign n_load  = CNT_W'(bit_cyc) * CNT_W'(char_factor(burst)) + CNT_W'(GUARD_CYC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= n_load;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // The count is N on the first WAIT cycle, so the cycle holding 1 is the last.
  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/uartb_tx_sched.sv
// Two-requester transmit scheduler for UARTB_CORE with auto baud reprogramming and pacing.
// Define UARTB_SCHED_RR_EN for round-robin arbitration; default is fixed priority (req0 wins).
module uartb_tx_sched
  import uartb_pkg::*;
#(
  parameter int GUARD_CYC = 2,
  parameter int CNT_W     = 22
) (
  input logic              clk,
  input logic              rst_n,
  uartb_tx_sched_if.slave  bus
);

  state_t      state;
  logic        prog_ok;
  logic [15:0] loaded_div;
  logic [15:0] lat_div;
  logic        lat_burst;
  logic [31:0] lat_data;

  logic        any_vld;
  logic        gnt;
  logic [31:0] gnt_data;
  logic        gnt_burst;
  logic        need_cfg;
  logic [31:0] cfg_word;
  logic        tmr_done;

`ifdef UARTB_SCHED_RR_EN
  logic rr_ptr;
`endif

  always_comb begin
    any_vld = bus.req0_valid | bus.req1_valid;
`ifdef UARTB_SCHED_RR_EN
    gnt = (bus.req0_valid && bus.req1_valid) ? rr_ptr : bus.req1_valid;
`else
    gnt = ~bus.req0_valid;
`endif
    gnt_data  = gnt ? bus.req1_data  : bus.req0_data;
    gnt_burst = gnt ? bus.req1_burst : bus.req0_burst;
    need_cfg  = !prog_ok || (gnt_burst != bus.cur_mode) || (bus.cfg_div != loaded_div);
    cfg_word  = {16'b0, bus.cfg_div};
    cfg_word[MODE_BIT] = gnt_burst;
  end

  // Request payload is captured at grant and needs no reset.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && any_vld) begin
      lat_data  <= gnt_data;
      lat_burst <= gnt_burst;
      lat_div   <= bus.cfg_div;
    end
  end

  // Outputs are registered one edge ahead so each strobe lines up with its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      prog_ok         <= 1'b0;
      loaded_div      <= '0;
      bus.req0_ready  <= 1'b0;
      bus.req1_ready  <= 1'b0;
      bus.uart_d      <= '0;
      bus.uart_wrtx   <= 1'b0;
      bus.uart_wrbaud <= 1'b0;
      bus.busy        <= 1'b0;
      bus.cur_mode    <= 1'b0;
      bus.grant_id    <= 1'b0;
`ifdef UARTB_SCHED_RR_EN
      rr_ptr          <= 1'b0;
`endif
    end else begin
      bus.req0_ready  <= 1'b0;
      bus.req1_ready  <= 1'b0;
      bus.uart_wrtx   <= 1'b0;
      bus.uart_wrbaud <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_vld) begin
            bus.grant_id   <= gnt;
            bus.req0_ready <= ~gnt;
            bus.req1_ready <= gnt;
            bus.busy       <= 1'b1;
`ifdef UARTB_SCHED_RR_EN
            rr_ptr         <= ~gnt;
`endif
            if (need_cfg) begin
              state           <= ST_CFG;
              bus.uart_wrbaud <= 1'b1;
              bus.uart_d      <= cfg_word;
              bus.cur_mode    <= gnt_burst;
              loaded_div      <= bus.cfg_div;
              prog_ok         <= 1'b1;
            end else begin
              state         <= ST_SEND;
              bus.uart_wrtx <= 1'b1;
              bus.uart_d    <= gnt_data;
            end
          end
        end
        ST_CFG: state <= ST_SETTLE;
        ST_SETTLE: begin
          state         <= ST_SEND;
          bus.uart_wrtx <= 1'b1;
          bus.uart_d    <= lat_data;
        end
        ST_SEND: state <= ST_WAIT;
        ST_WAIT: begin
          if (tmr_done) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uartb_char_timer #(
    .GUARD_CYC (GUARD_CYC),
    .CNT_W     (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == ST_SEND),
    .div   (lat_div),
    .burst (lat_burst),
    .done  (tmr_done)
  );

endmodule
